// File: rtl/csr_mach_unit.sv
// csr_mach_unit: machine-mode CSR file with counters, interrupt controller,
// WFI stall FSM and trap/mret PC redirect for the EX stage.
module csr_mach_unit #(
    parameter int DATA_BITS    = 32,
    parameter int ADDR_BITS    = 32,
    parameter int CSRADDR_BITS = 12,
    parameter int NUM_IRQ      = 2,
    parameter int CNT_BITS     = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    input  logic [ADDR_BITS-1:0]    pc,
    input  logic [CSRADDR_BITS-1:0] csr_addr,
    input  logic [DATA_BITS-1:0]    rs1_rdata,
    input  logic                    wr,
    input  logic                    set,
    input  logic                    clr,
    input  logic                    mret,
    input  logic                    wfi,
    input  logic                    retire,
    input  logic [NUM_IRQ-1:0]      irq_i,
    output logic [DATA_BITS-1:0]    rd_wdata,
    output logic                    stall_o,
    output logic                    redirect_o,
    output logic [ADDR_BITS-1:0]    redirect_pc_o
);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CSRADDR_BITS-1:0] A_MSTATUS  = CSRADDR_BITS'(12'h300);
    localparam logic [CSRADDR_BITS-1:0] A_MIE      = CSRADDR_BITS'(12'h304);
    localparam logic [CSRADDR_BITS-1:0] A_MTVEC    = CSRADDR_BITS'(12'h305);
    localparam logic [CSRADDR_BITS-1:0] A_MEPC     = CSRADDR_BITS'(12'h341);
    localparam logic [CSRADDR_BITS-1:0] A_MCAUSE   = CSRADDR_BITS'(12'h342);
    localparam logic [CSRADDR_BITS-1:0] A_MIP      = CSRADDR_BITS'(12'h344);
    localparam logic [CSRADDR_BITS-1:0] A_CYCLE    = CSRADDR_BITS'(12'hC00);
    localparam logic [CSRADDR_BITS-1:0] A_CYCLEH   = CSRADDR_BITS'(12'hC80);
    localparam logic [CSRADDR_BITS-1:0] A_INSTRET  = CSRADDR_BITS'(12'hC02);
    localparam logic [CSRADDR_BITS-1:0] A_INSTRETH = CSRADDR_BITS'(12'hC82);

    typedef enum logic [1:0] {RUN, WFI, REDIR} state_t;

    // line 0 -> MEIP(11), line 1 -> MTIP(7), the rest fill the platform range from bit 16
    function automatic logic [IW-1:0] irq_bit(input int k);
        return IW'(k == 0 ? 11 : k == 1 ? 7 : 14 + k);
    endfunction

    state_t                 state, state_nx;
    logic [ADDR_BITS-1:0]   target_r, target_nx;
    logic                   mst_mie, mst_mpie;
    logic [DATA_BITS-1:0]   mie_r, mtvec_r, mepc_r, mcause_r;
    logic [CNT_BITS-1:0]    cycle_r, instret_r;
    logic [DATA_BITS-1:0]   mip, pend, mstatus, new_val;
    logic [IW-1:0]          code;
    logic                   run, any_pend, take, do_op, do_mret, do_wfi;

    always_comb begin
        mip = '0;
        for (int k = 0; k < NUM_IRQ; k++)
            mip = mip | (DATA_BITS'((irq_i >> k) & NUM_IRQ'(1)) << irq_bit(k));
    end

    assign pend     = mip & mie_r;
    assign any_pend = |pend;

    // descending scan so the lowest-indexed pending line ends up in code
    always_comb begin
        code = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            code = |(pend & (DATA_BITS'(1) << irq_bit(k))) ? irq_bit(k) : code;
    end

    assign mstatus = DATA_BITS'({2'b11, 3'b000, mst_mpie, 3'b000, mst_mie, 3'b000});

    always_comb begin
        rd_wdata = '0;
        case (csr_addr)
            A_MSTATUS:  rd_wdata = mstatus;
            A_MIE:      rd_wdata = mie_r;
            A_MTVEC:    rd_wdata = mtvec_r;
            A_MEPC:     rd_wdata = mepc_r;
            A_MCAUSE:   rd_wdata = mcause_r;
            A_MIP:      rd_wdata = mip;
            A_CYCLE:    rd_wdata = DATA_BITS'(cycle_r);
            A_CYCLEH:   rd_wdata = DATA_BITS'(64'(cycle_r) >> 32);
            A_INSTRET:  rd_wdata = DATA_BITS'(instret_r);
            A_INSTRETH: rd_wdata = DATA_BITS'(64'(instret_r) >> 32);
            default:    rd_wdata = '0;
        endcase
    end

    assign new_val = wr ? rs1_rdata : set ? (rd_wdata | rs1_rdata) : (rd_wdata & ~rs1_rdata);
    assign run     = state == RUN;
    assign take    = run & ex_valid & mst_mie & any_pend;
    assign do_op   = run & ex_valid & ~take & (wr | set | clr);
    assign do_mret = run & ex_valid & ~take & mret;
    assign do_wfi  = run & ex_valid & ~take & wfi & ~any_pend;

    always_comb begin
        state_nx  = state;
        target_nx = target_r;
        case (state)
            RUN: begin
                if (take) begin
                    state_nx  = REDIR;
                    target_nx = ADDR_BITS'(mtvec_r);
                end else if (do_mret) begin
                    state_nx  = REDIR;
                    target_nx = ADDR_BITS'(mepc_r);
                end else if (do_wfi) begin
                    state_nx  = WFI;
                end
            end
            WFI:     state_nx = any_pend ? RUN : WFI;
            REDIR:   state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign stall_o       = (state == WFI) & ~any_pend;
    assign redirect_o    = state == REDIR;
    assign redirect_pc_o = target_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            target_r <= '0;
        end else begin
            state    <= state_nx;
            target_r <= target_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie   <= 1'b0;
            mst_mpie  <= 1'b0;
            mie_r     <= '0;
            mtvec_r   <= '0;
            mepc_r    <= '0;
            mcause_r  <= '0;
            cycle_r   <= '0;
            instret_r <= '0;
        end else begin
            cycle_r <= cycle_r + CNT_BITS'(1);
            if (retire)
                instret_r <= instret_r + CNT_BITS'(1);
            if (take) begin
                mepc_r   <= DATA_BITS'(pc) & ~DATA_BITS'(3);
                mcause_r <= {1'b1, (DATA_BITS-1)'(code)};
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (do_mret) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (do_op) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mst_mie  <= new_val[3];
                        mst_mpie <= new_val[7];
                    end
                    A_MIE:    mie_r    <= new_val;
                    A_MTVEC:  mtvec_r  <= new_val & ~DATA_BITS'(3);
                    A_MEPC:   mepc_r   <= new_val & ~DATA_BITS'(3);
                    A_MCAUSE: mcause_r <= new_val;
                    default: ;
                endcase
            end
        end
    end
endmodule
